im_fetch_ctrl: RTL and testbench
================================

Name: im_fetch_ctrl

Overview:
- Fetch sequencer for the instruction memory.
- Owns the program counter and drives the IM word address.
- Applies hazard-unit stalls and ID-stage branch/jump redirects.
- Bounds- and alignment-checks every fetch address; an illegal target parks the front end in a fault state until reset.

Parameters:
- PC_BASE, 32'h0000_3000, first instruction address and reset PC.
- IM_WORDS, 4096, IM depth in words; legal range is [PC_BASE, PC_BASE + 4*IM_WORDS).
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  leave IDLE and begin fetching (level, sampled each cycle)
- stall  input  1  hazard unit freeze of IF; hold PC
- redirect  input  1  ID stage resolved a taken branch/jump this cycle
- redirect_pc  input  32  target of the redirect
- pc  output  32  current fetch address, drives IM addr
- pc_plus4  output  32  pc + 4, forwarded to IF/ID
- if_valid  output  1  pc is a legal fetch this cycle
- fault  output  1  sticky illegal-target indication
- fault_pc  output  32  offending target address captured on fault entry
- fetch_cnt  output  CNT_W  number of fetches accepted into IF/ID

Behaviour:
- Reset values: state=IDLE, pc=PC_BASE, if_valid=0, fault=0, fault_pc=0, fetch_cnt=0. Reset wins over every other input in the same cycle, in any state.
- States: IDLE, RUN, FAULT.
- IDLE:
  - pc holds PC_BASE; if_valid=0; stall and redirect are ignored.
  - start=1 -> RUN next cycle, with pc still PC_BASE.
- RUN:
  - if_valid=1. The next-PC candidate is chosen in this priority order:
    - stall=1: hold pc (redirect ignored; the branch is not yet resolved).
    - else redirect=1: candidate = redirect_pc.
    - else: candidate = pc + 4 (32-bit wrap, no carry out).
  - A fetch is accepted (fetch_cnt += 1, wrapping at 2^CNT_W) on every RUN cycle with stall=0.
  - Legality check on a non-stall candidate: candidate[1:0]==0 and PC_BASE <= candidate < PC_BASE + 4*IM_WORDS, using unsigned 32-bit compares.
    - Legal: pc <= candidate.
    - Illegal: pc holds, fault_pc <= candidate, fault <= 1, state -> FAULT. The current fetch is still counted.
  - Sequential run-off (pc = last word, no redirect) is an illegal candidate, giving a fault with fault_pc = PC_BASE + 4*IM_WORDS.
- FAULT:
  - if_valid=0; pc, fault_pc and fetch_cnt frozen; fault=1.
  - start, stall and redirect are ignored. Only reset exits.
- Latency: combinational pc -> IM addr. A redirect seen on edge N makes pc = target in the cycle after N.
- pc_plus4 = pc + 4 combinationally, in all states.
- start is ignored outside IDLE.

Test Plan:
- Reset, start=1 one cycle, no stall/redirect for 4 cycles -> pc 3000, 3000, 3004, 3008, 300C; fetch_cnt=4; if_valid=1 from the RUN cycle onward.
- In RUN at pc=3010: stall=1 with redirect=1 (redirect_pc=3100) for 2 cycles, then stall=0 with redirect=1 -> pc holds 3010 twice, then 3100; fetch_cnt unchanged during the stall.
- redirect_pc=3102 (misaligned) -> fault=1, fault_pc=3102, pc frozen, if_valid=0; further start/redirect have no effect; reset -> pc=3000, fault=0, IDLE.
- redirect_pc=2FFC and, separately, 7000 with IM_WORDS=4096 -> both fault; redirect_pc=6FFC -> legal, pc=6FFC; the next sequential step faults with fault_pc=7000.
- Reset asserted mid-RUN together with redirect=1 and start=1 -> next cycle pc=3000, state IDLE, fetch_cnt=0, if_valid=0.
- CNT_W=4, 16 unstalled fetches -> fetch_cnt wraps to 0, with no fault raised.

Source files
------------

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, applies stalls and redirects,
// counts accepted fetches, and parks in FAULT on an illegal fetch target.
module im_fetch_ctrl #(
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             if_valid,
  output logic             fault,
  output logic [31:0]      fault_pc,
  output logic [CNT_W-1:0] fetch_cnt
);

  // First address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = PC_BASE + 32'(4 * IM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state_r, state_n_s;
  logic [31:0]      pc_r, pc_n_s;
  logic [31:0]      fault_pc_r, fault_pc_n_s;
  logic [CNT_W-1:0] fetch_cnt_r, fetch_cnt_n_s;
  logic [31:0]      seq_pc_s;
  logic [31:0]      cand_s;

  // Word-aligned and inside [PC_BASE, PC_LIMIT), unsigned compares.
  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr >= PC_BASE) && (addr < PC_LIMIT);
  endfunction

  // Sequential successor and non-stall next-PC candidate.
  always_comb begin
    seq_pc_s = pc_r + 32'd4;
    if (redirect) begin
      cand_s = redirect_pc;
    end else begin
      cand_s = seq_pc_s;
    end
  end

  // Next-state, next-PC, fault capture and fetch counting.
  always_comb begin
    state_n_s     = state_r;
    pc_n_s        = pc_r;
    fault_pc_n_s  = fault_pc_r;
    fetch_cnt_n_s = fetch_cnt_r;
    case (state_r)
      IDLE: begin
        pc_n_s = PC_BASE;
        if (start) begin
          state_n_s = RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        if (stall) begin
          pc_n_s = pc_r;
        end else begin
          // The fetch presented this cycle is accepted even if the next
          // target turns out to be illegal.
          fetch_cnt_n_s = fetch_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (is_legal(cand_s)) begin
            pc_n_s = cand_s;
          end else begin
            fault_pc_n_s = cand_s;
            state_n_s    = FAULT;
          end
        end
      end
      FAULT: begin
        state_n_s = FAULT;
      end
      default: begin
        state_n_s = IDLE;
        pc_n_s    = PC_BASE;
      end
    endcase
  end

  // State registers with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pc_r        <= PC_BASE;
      fault_pc_r  <= 32'h0000_0000;
      fetch_cnt_r <= '0;
    end else begin
      state_r     <= state_n_s;
      pc_r        <= pc_n_s;
      fault_pc_r  <= fault_pc_n_s;
      fetch_cnt_r <= fetch_cnt_n_s;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    pc        = pc_r;
    pc_plus4  = seq_pc_s;
    if_valid  = (state_r == RUN);
    fault     = (state_r == FAULT);
    fault_pc  = fault_pc_r;
    fetch_cnt = fetch_cnt_r;
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed self-checking bench for im_fetch_ctrl.
module tb_im_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc_plus4, fault_pc;
  logic        if_valid, fault;
  logic [31:0] fetch_cnt;
  logic [31:0] pc4, pc_plus4_4, fault_pc4;
  logic        if_valid4, fault4;
  logic [3:0]  fetch_cnt4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  im_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .pc_plus4(pc_plus4), .if_valid(if_valid),
    .fault(fault), .fault_pc(fault_pc), .fetch_cnt(fetch_cnt)
  );

  im_fetch_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc4), .pc_plus4(pc_plus4_4), .if_valid(if_valid4),
    .fault(fault4), .fault_pc(fault_pc4), .fetch_cnt(fetch_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
    checks++; if (pc_plus4 !== 32'h3004) begin errors++; $display("FAIL reset_pc_plus4 got %h want %h", pc_plus4, 32'h3004); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
    checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc got %h want 0", fault_pc); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010};
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL start_pc got %h want %h", pc, 32'h3000); end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL start_if_valid got %b want 1", if_valid); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
      checks++; if (fetch_cnt !== 32'(i)) begin errors++; $display("FAIL seq_cnt[%0d] got %0d want %0d", i, fetch_cnt, i); end
    end
    checks++; if (pc_plus4 !== 32'h3014) begin errors++; $display("FAIL seq_pc_plus4 got %h want %h", pc_plus4, 32'h3014); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL stall_pc[%0d] got %h want %h", i, pc, 32'h3010); end
      checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL stall_cnt[%0d] got %0d want 4", i, fetch_cnt); end
    end
    stall = 1'b0;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'h3100) begin errors++; $display("FAIL redirect_pc got %h want %h", pc, 32'h3100); end
    checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL redirect_cnt got %0d want 5", fetch_cnt); end
  endtask

  task automatic test_misaligned_fault();
    redirect = 1'b1; redirect_pc = 32'h3102;
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %b want 1", fault); end
    checks++; if (fault_pc !== 32'h3102) begin errors++; $display("FAIL mis_fault_pc got %h want %h", fault_pc, 32'h3102); end
    checks++; if (pc !== 32'h3100) begin errors++; $display("FAIL mis_pc got %h want %h", pc, 32'h3100); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mis_if_valid got %b want 0", if_valid); end
    checks++; if (fetch_cnt !== 32'd6) begin errors++; $display("FAIL mis_cnt got %0d want 6", fetch_cnt); end
    start = 1'b1; redirect_pc = 32'h3200;
    tick(); tick();
    checks++; if (pc !== 32'h3100) begin errors++; $display("FAIL frozen_pc got %h want %h", pc, 32'h3100); end
    checks++; if (fault_pc !== 32'h3102) begin errors++; $display("FAIL frozen_fault_pc got %h want %h", fault_pc, 32'h3102); end
    checks++; if (fetch_cnt !== 32'd6) begin errors++; $display("FAIL frozen_cnt got %0d want 6", fetch_cnt); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL frozen_fault got %b want 1", fault); end
    reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL unfault_pc got %h want %h", pc, 32'h3000); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL unfault_fault got %b want 0", fault); end
    checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL unfault_fault_pc got %h want 0", fault_pc); end
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL idle_ignore_pc got %h want %h", pc, 32'h3000); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL idle_if_valid got %b want 0", if_valid); end
  endtask

  task automatic test_bounds();
    logic [31:0] bad [2];
    bad = '{32'h2FFC, 32'h7000};
    for (int i = 0; i < 2; i++) begin
      go_run();
      redirect = 1'b1; redirect_pc = bad[i];
      tick();
      redirect = 1'b0;
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL bound_fault[%0d] got %b want 1", i, fault); end
      checks++; if (fault_pc !== bad[i]) begin errors++; $display("FAIL bound_fault_pc[%0d] got %h want %h", i, fault_pc, bad[i]); end
      checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL bound_pc[%0d] got %h want %h", i, pc, 32'h3000); end
    end
    go_run();
    redirect = 1'b1; redirect_pc = 32'h6FFC;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'h6FFC) begin errors++; $display("FAIL last_word_pc got %h want %h", pc, 32'h6FFC); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL last_word_fault got %b want 0", fault); end
    checks++; if (pc_plus4 !== 32'h7000) begin errors++; $display("FAIL last_word_pc_plus4 got %h want %h", pc_plus4, 32'h7000); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL runoff_fault got %b want 1", fault); end
    checks++; if (fault_pc !== 32'h7000) begin errors++; $display("FAIL runoff_fault_pc got %h want %h", fault_pc, 32'h7000); end
    checks++; if (pc !== 32'h6FFC) begin errors++; $display("FAIL runoff_pc got %h want %h", pc, 32'h6FFC); end
    checks++; if (fetch_cnt !== 32'd2) begin errors++; $display("FAIL runoff_cnt got %0d want 2", fetch_cnt); end
  endtask

  task automatic test_reset_mid_run();
    go_run();
    tick(); tick();
    checks++; if (pc !== 32'h3008) begin errors++; $display("FAIL midrun_pre_pc got %h want %h", pc, 32'h3008); end
    reset = 1'b1; redirect = 1'b1; start = 1'b1; redirect_pc = 32'h3100;
    tick();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL midrun_pc got %h want %h", pc, 32'h3000); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL midrun_if_valid got %b want 0", if_valid); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL midrun_cnt got %0d want 0", fetch_cnt); end
    reset = 1'b0; redirect = 1'b0; start = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL midrun_idle got %b want 0", if_valid); end
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL midrun_idle_pc got %h want %h", pc, 32'h3000); end
  endtask

  task automatic test_cnt_wrap();
    go_run();
    for (int i = 0; i < 16; i++) tick();
    checks++; if (fetch_cnt4 !== 4'd0) begin errors++; $display("FAIL wrap_cnt4 got %0d want 0", fetch_cnt4); end
    checks++; if (fault4 !== 1'b0) begin errors++; $display("FAIL wrap_fault4 got %b want 0", fault4); end
    checks++; if (fetch_cnt !== 32'd16) begin errors++; $display("FAIL wrap_cnt32 got %0d want 16", fetch_cnt); end
    checks++; if (pc4 !== 32'h3040) begin errors++; $display("FAIL wrap_pc4 got %h want %h", pc4, 32'h3040); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_misaligned_fault();
    test_bounds();
    test_reset_mid_run();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
